axi_lite_cfg_master: RTL and testbench
======================================

// Module: axi_lite_cfg_master
// PURPOSE
//   AXI4-Lite master that turns single-beat config commands into AXI4-Lite write or read transactions.
//   Drives the NPU weight/threshold register slave from the host-side control logic or a boot loader.
//   Allows one transaction outstanding. Each command returns a response (read data, RESP code, timeout flag).
// PARAMETERS
//   C_M_AXI_ADDR_WIDTH  6    AXI address width (byte address, word-aligned)
//   C_M_AXI_DATA_WIDTH  32   AXI data width
//   TIMEOUT_CYCLES      255  cycles to wait for B/R before abort; 0 = wait forever
// PORTS
//   m_axi_aclk      in   1      clock
//   m_axi_areset    in   1      synchronous reset, active-high
//   cmd_valid       in   1      command valid
//   cmd_ready       out  1      command accepted when cmd_valid&&cmd_ready
//   cmd_write       in   1      1 = write, 0 = read
//   cmd_addr        in   AW     byte address
//   cmd_wdata       in   DW     write data
//   cmd_wstrb       in   DW/8   write strobes
//   rsp_valid       out  1      response valid, held until rsp_ready
//   rsp_ready       in   1      response consumed
//   rsp_rdata       out  DW     read data (0 for writes)
//   rsp_resp        out  2      BRESP/RRESP; 2'b00 on timeout
//   rsp_timeout     out  1      transaction aborted by timeout
//   busy            out  1      state != IDLE
//   stray_cnt       out  8      count of absorbed B/R beats arriving after a timeout; saturates at 255
//   m_axi_aw*/w*/b*/ar*/r*      full AXI4-Lite master channel set; awprot=arprot=3'b000
// BEHAVIOUR
//   Reset: all *valid, cmd_ready, rsp_* and busy outputs are 0. stray_cnt, the timeout counter and all
//     addr/data outputs are 0. State = IDLE. Reset mid-transaction abandons it; no response is issued.
//   Outputs are registered. cmd_ready = 1 only in IDLE (first cycle after reset release onward).
//   States and transitions:
//     IDLE    -> WR_AW_W on a write handshake; -> RD_AR on a read handshake; cmd fields latched.
//     WR_AW_W: awvalid and wvalid rise together on the cycle after acceptance. Each valid falls
//              independently on its own handshake; addr/data held stable while valid.
//              -> WR_B once both handshakes are done (same cycle or either order).
//     WR_B   : bready=1; timeout counter runs. -> RSP on B handshake, or on timeout.
//     RD_AR  : arvalid=1 until arready. -> RD_R.
//     RD_R   : rready=1; timeout counter runs. -> RSP on R handshake (capture rdata/rresp) or on timeout.
//     RSP    : rsp_valid=1 with fields stable. -> IDLE on rsp_ready.
//   VALID is never dropped before READY. Timeout applies only in WR_B/RD_R.
//   Timeout counter: cleared on entry to WR_B/RD_R. Expires when it reaches TIMEOUT_CYCLES without a handshake.
//     On expiry: rsp_timeout=1, rsp_resp=2'b00, rsp_rdata=0.
//   Stray absorption: in IDLE and RSP, bready=rready=1. Any B/R beat there increments stray_cnt.
//   rsp_valid rises the cycle after the B/R handshake.
//   Against the 1-cycle-ready register slave: cmd accept at t0, aw/w handshake at t2, B at t3, rsp_valid at t4.
//   Unaligned cmd_addr bits [1:0] are driven unchanged; alignment is the caller's job.
// TESTING
//   1. Write addr 0x20, data 0x000000C8, strb 0xF to slave model -> one AW/W, rsp_valid at t4,
//      rsp_resp=00, then read 0x20 returns 0x000000C8.
//   2. Slave asserts awready at t2 but wready only at t5 -> awvalid low from t3, wvalid held to t5
//      with data stable, exactly one B, rsp_resp=00.
//   3. TIMEOUT_CYCLES=16, slave never asserts bvalid -> rsp_valid with rsp_timeout=1 after 16 cycles in WR_B;
//      a late bvalid is then absorbed and stray_cnt=1.
//   4. Read of addr 0x3C, slave returns rresp=2'b10, rdata=0xDEADBEEF -> rsp_resp=10, rsp_rdata=0xDEADBEEF,
//      rsp_timeout=0.
//   5. rsp_ready held low 5 cycles -> rsp_* stable, cmd_ready=0, no new AXI activity; IDLE the cycle after rsp_ready.
//   6. Assert m_axi_areset while in WR_B -> next edge all valids=0, busy=0, no rsp_valid;
//      a following write completes normally.

Source files
------------

// File: rtl/axi_lite_cfg_master_if.sv
// AXI4-Lite channel bundle between the config master and its register slave.
interface axi_lite_cfg_master_if #(
    parameter int AW = 6,
    parameter int DW = 32
);
    logic            awvalid;
    logic            awready;
    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            wvalid;
    logic            wready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            bvalid;
    logic            bready;
    logic [1:0]      bresp;
    logic            arvalid;
    logic            arready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            rvalid;
    logic            rready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        output arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
        input  arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_lite_cfg_master.sv
// Single-outstanding AXI4-Lite master: one config command in, one AXI
// write or read out, one response back (data, resp code, timeout flag).
// Late B/R beats that arrive after an abort are absorbed and counted.
module axi_lite_cfg_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 6,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES     = 255
) (
    input  logic                              m_axi_aclk,
    input  logic                              m_axi_areset,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic                              rsp_timeout,
    output logic                              busy,
    output logic [7:0]                        stray_cnt,
    axi_lite_cfg_master_if.master             m_axi
);
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    // Last count value before expiry; only meaningful when TIMEOUT_CYCLES != 0.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP} state_t;

    state_t          state_q;
    logic            cmd_ready_q;
    logic            busy_q;
    logic            awvalid_q;
    logic            wvalid_q;
    logic            arvalid_q;
    logic            bready_q;
    logic            rready_q;
    logic [AW-1:0]   awaddr_q;
    logic [AW-1:0]   araddr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW/8-1:0] wstrb_q;
    logic            rsp_valid_q;
    logic [DW-1:0]   rsp_rdata_q;
    logic [1:0]      rsp_resp_q;
    logic            rsp_timeout_q;
    logic [15:0]     tmo_cnt_q;
    logic [7:0]      stray_cnt_q;
    logic [7:0]      stray_cnt_d;
    logic [1:0]      stray_hits;
    logic            tmo_expired;
    logic            aw_done;
    logic            w_done;

    // Saturating add for the stray-beat counter.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] n);
        logic [8:0] s;
        s = {1'b0, a} + {7'd0, n};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // Stray B/R beats, timeout expiry and AW/W completion for the current cycle.
    always_comb begin
        stray_hits = 2'd0;
        if (state_q == IDLE || state_q == RSP) begin
            stray_hits = {1'b0, m_axi.bvalid && bready_q} + {1'b0, m_axi.rvalid && rready_q};
        end
        stray_cnt_d = sat_add8(stray_cnt_q, stray_hits);
        tmo_expired = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == TMO_LAST);
        aw_done     = !awvalid_q || m_axi.awready;
        w_done      = !wvalid_q  || m_axi.wready;
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            bready_q      <= 1'b0;
            rready_q      <= 1'b0;
            awaddr_q      <= '0;
            araddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
            tmo_cnt_q     <= '0;
            stray_cnt_q   <= '0;
        end else begin
            stray_cnt_q <= stray_cnt_d;
            case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        bready_q    <= 1'b0;
                        rready_q    <= 1'b0;
                        if (cmd_write) begin
                            state_q   <= WR_AW_W;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            awaddr_q  <= cmd_addr;
                            wdata_q   <= cmd_wdata;
                            wstrb_q   <= cmd_wstrb;
                        end else begin
                            state_q   <= RD_AR;
                            arvalid_q <= 1'b1;
                            araddr_q  <= cmd_addr;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                        bready_q    <= 1'b1;
                        rready_q    <= 1'b1;
                    end
                end
                WR_AW_W: begin
                    // AW and W retire independently; move on once both have.
                    if (awvalid_q && m_axi.awready) awvalid_q <= 1'b0;
                    if (wvalid_q && m_axi.wready)   wvalid_q  <= 1'b0;
                    if (aw_done && w_done) begin
                        state_q   <= WR_B;
                        bready_q  <= 1'b1;
                        tmo_cnt_q <= '0;
                    end
                end
                WR_B: begin
                    if (m_axi.bvalid && bready_q) begin
                        state_q       <= RSP;
                        rready_q      <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= '0;
                        rsp_resp_q    <= m_axi.bresp;
                        rsp_timeout_q <= 1'b0;
                    end else if (tmo_expired) begin
                        state_q       <= RSP;
                        rready_q      <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= '0;
                        rsp_resp_q    <= 2'b00;
                        rsp_timeout_q <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end
                end
                RD_AR: begin
                    if (m_axi.arready) begin
                        state_q   <= RD_R;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        tmo_cnt_q <= '0;
                    end
                end
                RD_R: begin
                    if (m_axi.rvalid && rready_q) begin
                        state_q       <= RSP;
                        bready_q      <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= m_axi.rdata;
                        rsp_resp_q    <= m_axi.rresp;
                        rsp_timeout_q <= 1'b0;
                    end else if (tmo_expired) begin
                        state_q       <= RSP;
                        bready_q      <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= '0;
                        rsp_resp_q    <= 2'b00;
                        rsp_timeout_q <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign busy          = busy_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign stray_cnt     = stray_cnt_q;

    assign m_axi.awvalid = awvalid_q;
    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.araddr  = araddr_q;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.rready  = rready_q;
endmodule

// File: tb/tb_axi_lite_cfg_master.sv
// Directed bench for axi_lite_cfg_master against a small register-slave model
// with per-channel ready delays, a B-response gate and a forced read error.
module tb_axi_lite_cfg_master;
    localparam int AW = 6;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          rsp_timeout;
    logic          busy;
    logic [7:0]    stray_cnt;

    axi_lite_cfg_master_if #(.AW(AW), .DW(DW)) axi ();

    axi_lite_cfg_master #(
        .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES    (16)
    ) dut (
        .m_axi_aclk  (clk),
        .m_axi_areset(rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .stray_cnt   (stray_cnt),
        .m_axi       (axi.master)
    );

    always #5 clk = ~clk;

    int errors;
    int checks;

    // Slave model knobs and observation
    int            aw_dly, w_dly, ar_dly;
    logic          b_en, r_err;
    int            aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [AW-1:0] sl_awaddr, sl_araddr;
    logic [DW-1:0] sl_wdata;
    logic [3:0]    sl_wstrb;
    logic [DW-1:0] mem [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Slave: sample pre-edge values at negedge, react just after the posedge.
    initial begin
        logic          s_aw, s_awv, s_w, s_wv, s_ar, s_arv, s_b, s_r;
        logic [AW-1:0] s_awaddr, s_araddr;
        logic [DW-1:0] s_wdata;
        logic [3:0]    s_wstrb;
        int            aw_cnt, w_cnt, ar_cnt;
        logic          aw_got, w_got, ar_got;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
        sl_awaddr = '0; sl_araddr = '0; sl_wdata = '0; sl_wstrb = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 2'b00;
        axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rresp = 2'b00;
        forever begin
            @(negedge clk);
            s_aw = axi.awvalid && axi.awready;  s_awv = axi.awvalid && !axi.awready;
            s_w  = axi.wvalid  && axi.wready;   s_wv  = axi.wvalid  && !axi.wready;
            s_ar = axi.arvalid && axi.arready;  s_arv = axi.arvalid && !axi.arready;
            s_b  = axi.bvalid  && axi.bready;   s_r   = axi.rvalid  && axi.rready;
            s_awaddr = axi.awaddr; s_araddr = axi.araddr;
            s_wdata  = axi.wdata;  s_wstrb  = axi.wstrb;
            @(posedge clk);
            #1;
            if (rst) begin
                axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
                axi.arready = 0; axi.rvalid = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
                aw_got = 0; w_got = 0; ar_got = 0;
            end else begin
                if (s_b) begin axi.bvalid = 0; b_hs++; end
                if (s_r) begin axi.rvalid = 0; r_hs++; end
                if (s_aw) begin
                    axi.awready = 0; aw_cnt = 0; aw_got = 1; sl_awaddr = s_awaddr; aw_hs++;
                end else if (s_awv) begin
                    aw_cnt++;
                    if (aw_cnt >= aw_dly) axi.awready = 1;
                end
                if (s_w) begin
                    axi.wready = 0; w_cnt = 0; w_got = 1; sl_wdata = s_wdata; sl_wstrb = s_wstrb; w_hs++;
                end else if (s_wv) begin
                    w_cnt++;
                    if (w_cnt >= w_dly) axi.wready = 1;
                end
                if (s_ar) begin
                    axi.arready = 0; ar_cnt = 0; ar_got = 1; sl_araddr = s_araddr; ar_hs++;
                end else if (s_arv) begin
                    ar_cnt++;
                    if (ar_cnt >= ar_dly) axi.arready = 1;
                end
                if (aw_got && w_got && b_en && !axi.bvalid) begin
                    for (int i = 0; i < 4; i++)
                        if (sl_wstrb[i]) mem[sl_awaddr[5:2]][8*i +: 8] = sl_wdata[8*i +: 8];
                    axi.bvalid = 1; axi.bresp = 2'b00; aw_got = 0; w_got = 0;
                end
                if (ar_got && !axi.rvalid) begin
                    axi.rdata  = r_err ? 32'hDEADBEEF : mem[sl_araddr[5:2]];
                    axi.rresp  = r_err ? 2'b10 : 2'b00;
                    axi.rvalid = 1; ar_got = 0;
                end
            end
        end
    end

    // Called at a negedge; handshake happens at the next posedge (t0), returns at the negedge after t0.
    task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
        int n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        chk("send_cmd_ready", 32'(cmd_ready), 1);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        @(negedge clk);
        cmd_valid = 0;
    endtask

    // Latency = number of posedges after t0 before rsp_valid is seen.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
    endtask

    task automatic take_rsp();
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, b0, aw0, w0, act0;
        errors = 0; checks = 0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 0;
        aw_dly = 1; w_dly = 1; ar_dly = 1; b_en = 1; r_err = 0;
        rst = 1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_busy",      32'(busy), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_tmo",   32'(rsp_timeout), 0);
        chk("rst_stray",     32'(stray_cnt), 0);
        chk("rst_valids",    32'({axi.awvalid, axi.wvalid, axi.arvalid}), 0);
        chk("rst_readies",   32'({axi.bready, axi.rready}), 0);
        chk("rst_awaddr",    32'(axi.awaddr), 0);
        chk("rst_wdata",     axi.wdata, 0);
        rst = 0;
        @(negedge clk);
        chk("idle_cmd_ready", 32'(cmd_ready), 1);
        chk("idle_readies",   32'({axi.bready, axi.rready}), 32'h3);

        // 1: write 0x20 then read it back, 1-cycle-ready slave
        send(1, 6'h20, 32'h000000C8, 4'hF);
        chk("t1_busy", 32'(busy), 1);
        wait_rsp(lat);
        chk("t1_wr_lat",  lat, 3);
        chk("t1_wr_resp", 32'(rsp_resp), 0);
        chk("t1_wr_tmo",  32'(rsp_timeout), 0);
        chk("t1_wr_rdata", rsp_rdata, 0);
        chk("t1_awaddr",  32'(sl_awaddr), 32'h20);
        chk("t1_wstrb",   32'(sl_wstrb), 32'hF);
        chk("t1_hs",      32'(aw_hs * 100 + w_hs * 10 + b_hs), 111);
        take_rsp();
        chk("t1_idle_ready", 32'(cmd_ready), 1);
        chk("t1_idle_busy",  32'(busy), 0);
        send(0, 6'h20, 32'h0, 4'h0);
        wait_rsp(lat);
        chk("t1_rd_lat",   lat, 3);
        chk("t1_rd_rdata", rsp_rdata, 32'h000000C8);
        chk("t1_rd_resp",  32'(rsp_resp), 0);
        take_rsp();

        // 4: read error response with data
        r_err = 1;
        send(0, 6'h3C, 32'h0, 4'h0);
        wait_rsp(lat);
        chk("t4_lat",    lat, 3);
        chk("t4_resp",   32'(rsp_resp), 32'h2);
        chk("t4_rdata",  rsp_rdata, 32'hDEADBEEF);
        chk("t4_tmo",    32'(rsp_timeout), 0);
        chk("t4_araddr", 32'(sl_araddr), 32'h3C);
        take_rsp();
        r_err = 0;

        // 2: awready early, wready late; AW drops first, W held with stable data
        w_dly = 4;
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
        send(1, 6'h10, 32'hA5A55A5A, 4'hF);
        for (int k = 0; k < 6; k++) begin
            chk("t2_awvalid", 32'(axi.awvalid), 32'(k < 2));
            chk("t2_wvalid",  32'(axi.wvalid),  32'(k < 5));
            if (k < 5) chk("t2_wdata", axi.wdata, 32'hA5A55A5A);
            @(negedge clk);
        end
        chk("t2_rsp_valid", 32'(rsp_valid), 1);
        chk("t2_resp",      32'(rsp_resp), 0);
        chk("t2_aw_once",   aw_hs - aw0, 1);
        chk("t2_w_once",    w_hs - w0, 1);
        chk("t2_b_once",    b_hs - b0, 1);
        take_rsp();
        w_dly = 1;

        // 5: response back-pressure
        send(1, 6'h08, 32'h00000055, 4'hF);
        wait_rsp(lat);
        chk("t5_lat", lat, 3);
        act0 = aw_hs + w_hs + b_hs + ar_hs + r_hs;
        for (int k = 0; k < 5; k++) begin
            chk("t5_rsp_valid", 32'(rsp_valid), 1);
            chk("t5_rsp_resp",  32'(rsp_resp), 0);
            chk("t5_rsp_rdata", rsp_rdata, 0);
            chk("t5_cmd_ready", 32'(cmd_ready), 0);
            chk("t5_valids",    32'({axi.awvalid, axi.wvalid, axi.arvalid}), 0);
            @(negedge clk);
        end
        chk("t5_no_activity", aw_hs + w_hs + b_hs + ar_hs + r_hs, act0);
        take_rsp();
        chk("t5_idle_ready", 32'(cmd_ready), 1);
        chk("t5_idle_busy",  32'(busy), 0);
        chk("t5_rsp_clear",  32'(rsp_valid), 0);

        // 3: B never comes -> timeout after 16 cycles in WR_B, then late B absorbed
        b_en = 0;
        b0 = b_hs;
        send(1, 6'h0C, 32'h00000077, 4'hF);
        wait_rsp(lat);
        chk("t3_lat",   lat, 18);
        chk("t3_tmo",   32'(rsp_timeout), 1);
        chk("t3_resp",  32'(rsp_resp), 0);
        chk("t3_rdata", rsp_rdata, 0);
        chk("t3_no_b",  b_hs - b0, 0);
        take_rsp();
        chk("t3_stray0", 32'(stray_cnt), 0);
        b_en = 1;
        repeat (3) @(negedge clk);
        chk("t3_stray1",    32'(stray_cnt), 1);
        chk("t3_b_taken",   b_hs - b0, 1);
        chk("t3_bvalid",    32'(axi.bvalid), 0);
        chk("t3_no_rsp",    32'(rsp_valid), 0);
        chk("t3_idle_busy", 32'(busy), 0);

        // 6: reset while waiting in WR_B, then normal operation resumes
        b_en = 0;
        send(1, 6'h14, 32'h00000099, 4'hF);
        repeat (3) @(negedge clk);
        chk("t6_in_wrb_busy",   32'(busy), 1);
        chk("t6_in_wrb_bready", 32'(axi.bready), 1);
        rst = 1;
        @(negedge clk);
        chk("t6_rst_valids",    32'({axi.awvalid, axi.wvalid, axi.arvalid}), 0);
        chk("t6_rst_busy",      32'(busy), 0);
        chk("t6_rst_rsp",       32'(rsp_valid), 0);
        chk("t6_rst_cmd_ready", 32'(cmd_ready), 0);
        chk("t6_rst_stray",     32'(stray_cnt), 0);
        rst = 0;
        b_en = 1;
        @(negedge clk);
        chk("t6_post_ready", 32'(cmd_ready), 1);
        send(1, 6'h04, 32'h12345678, 4'hF);
        wait_rsp(lat);
        chk("t6_wr_lat",  lat, 3);
        chk("t6_wr_resp", 32'(rsp_resp), 0);
        chk("t6_wr_tmo",  32'(rsp_timeout), 0);
        take_rsp();
        send(1, 6'h04, 32'hFFFFFFFF, 4'b0011);
        wait_rsp(lat);
        chk("t6_pwr_lat", lat, 3);
        take_rsp();
        send(0, 6'h04, 32'h0, 4'h0);
        wait_rsp(lat);
        chk("t6_rd_lat",   lat, 3);
        chk("t6_rd_rdata", rsp_rdata, 32'h1234FFFF);
        take_rsp();
        chk("t6_no_stray", 32'(stray_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
